// File: rtl/npc_pc_unit_pkg.sv
// Shared encodings, reset defaults and result types for the fetch PC unit.
// Imported by the interface, the next-PC calculator and the top.
package npc_pc_unit_pkg;

    localparam logic [2:0] BR_NONE  = 3'd0;
    localparam logic [2:0] BR_BEQ   = 3'd1;
    localparam logic [2:0] BR_BNE   = 3'd2;
    localparam logic [2:0] BR_BEZAL = 3'd3;
    localparam logic [2:0] BR_J     = 3'd4;
    localparam logic [2:0] BR_JAL   = 3'd5;
    localparam logic [2:0] BR_JR    = 3'd6;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic        link_we;
        logic [31:0] link_pc;
        logic        jr_misalign;
    } npc_res_t;

    // Word offset of a conditional branch, sign-extended and scaled to bytes.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/npc_pc_unit_if.sv
// D-stage branch inputs and fetch-side outputs of the PC unit.
// The pipeline drives through master; the PC unit attaches as slave.
interface npc_pc_unit_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic             d_valid;
    logic [2:0]       d_br_type;
    logic             d_zero;
    logic             d_bezal;
    logic [31:0]      d_pc;
    logic [15:0]      d_imm16;
    logic [25:0]      d_index26;
    logic [31:0]      d_rs_val;
    logic [31:0]      f_pc;
    logic             f_valid;
    logic             d_taken;
    logic             d_link_we;
    logic [31:0]      d_link_pc;
    logic             align_err;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output stall, d_valid, d_br_type, d_zero, d_bezal, d_pc, d_imm16, d_index26, d_rs_val,
        input  f_pc, f_valid, d_taken, d_link_we, d_link_pc, align_err, taken_cnt
    );

    modport slave (
        input  stall, d_valid, d_br_type, d_zero, d_bezal, d_pc, d_imm16, d_index26, d_rs_val,
        output f_pc, f_valid, d_taken, d_link_we, d_link_pc, align_err, taken_cnt
    );
endinterface

// File: rtl/npc_pc_unit_npc_calc.sv
// Combinational branch resolution for the D stage: taken decision, target and link.
// en folds together D-stage valid and the unit being out of BOOT.
module npc_pc_unit_npc_calc
    import npc_pc_unit_pkg::*;
(
    input  logic        en,
    input  logic [2:0]  br_type,
    input  logic        zero,
    input  logic        bezal,
    input  logic [31:0] pc,
    input  logic [15:0] imm16,
    input  logic [25:0] index26,
    input  logic [31:0] rs_val,
    output npc_res_t    res
);
    logic [31:0] pc_plus4;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;

    assign pc_plus4 = pc + 32'd4;
    assign br_tgt   = pc_plus4 + br_offset(imm16);
    // Jump region comes from the delay-slot address, not the jump itself.
    assign j_tgt    = {pc_plus4[31:28], index26, 2'b00};

    always_comb begin
        res             = '0;
        res.link_pc     = pc + 32'd8;
        res.target      = pc_plus4;
        if (en) begin
            case (br_type)
                BR_BEQ: begin
                    res.taken  = zero;
                    res.target = br_tgt;
                end
                BR_BNE: begin
                    res.taken  = !zero;
                    res.target = br_tgt;
                end
                BR_BEZAL: begin
                    res.taken   = bezal;
                    res.target  = br_tgt;
                    res.link_we = bezal;
                end
                BR_J: begin
                    res.taken  = 1'b1;
                    res.target = j_tgt;
                end
                BR_JAL: begin
                    res.taken   = 1'b1;
                    res.target  = j_tgt;
                    res.link_we = 1'b1;
                end
                BR_JR: begin
                    res.taken       = 1'b1;
                    res.target      = rs_val;
                    res.jr_misalign = (rs_val[1:0] != 2'b00);
                end
                default: begin
                    res.taken = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/npc_pc_unit.sv
// Fetch PC register with next-PC select, sticky JR alignment error and taken-branch counter.
//  state   | meaning
//  ST_BOOT | first cycle after reset: fetch invalid, PC held, D stage ignored
//  ST_RUN  | normal fetch: PC advances or redirects on every unstalled edge
module npc_pc_unit
    import npc_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input logic          clk,
    input logic          reset,
    npc_pc_unit_if.slave bus
);
    logic [0:0]       state;
    logic [31:0]      pc;
    logic             err;
    logic [CNT_W-1:0] cnt;
    npc_res_t         res;
    logic             run;

    assign run = (state == ST_RUN);

    npc_pc_unit_npc_calc u_calc (
        .en      (run && bus.d_valid),
        .br_type (bus.d_br_type),
        .zero    (bus.d_zero),
        .bezal   (bus.d_bezal),
        .pc      (bus.d_pc),
        .imm16   (bus.d_imm16),
        .index26 (bus.d_index26),
        .rs_val  (bus.d_rs_val),
        .res     (res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_BOOT;
            pc    <= RESET_PC;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= ST_RUN;
            if (run && !bus.stall) begin
                pc <= res.taken ? res.target : pc + 32'd4;
                if (res.jr_misalign) begin
                    err <= 1'b1;
                end
                if (res.taken && (cnt != {CNT_W{1'b1}})) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.f_pc      = pc;
    assign bus.f_valid   = run;
    assign bus.d_taken   = res.taken;
    assign bus.d_link_we = res.link_we;
    assign bus.d_link_pc = res.link_pc;
    assign bus.align_err = err;
    assign bus.taken_cnt = cnt;
endmodule

// File: tb/tb_npc_pc_unit.sv
// Directed bench for npc_pc_unit: a 16-bit-counter instance and a 2-bit-counter
// instance share one stimulus stream so saturation shows up alongside normal counting.
module tb_npc_pc_unit;
    import npc_pc_unit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    npc_pc_unit_if #(.CNT_W(16)) ifc_a ();
    npc_pc_unit_if #(.CNT_W(2))  ifc_b ();

    npc_pc_unit #(.RESET_PC(32'h0000_3000), .CNT_W(16)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc_a.slave)
    );

    npc_pc_unit #(.RESET_PC(32'h0000_3000), .CNT_W(2)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc_b.slave)
    );

    assign ifc_b.stall     = ifc_a.stall;
    assign ifc_b.d_valid   = ifc_a.d_valid;
    assign ifc_b.d_br_type = ifc_a.d_br_type;
    assign ifc_b.d_zero    = ifc_a.d_zero;
    assign ifc_b.d_bezal   = ifc_a.d_bezal;
    assign ifc_b.d_pc      = ifc_a.d_pc;
    assign ifc_b.d_imm16   = ifc_a.d_imm16;
    assign ifc_b.d_index26 = ifc_a.d_index26;
    assign ifc_b.d_rs_val  = ifc_a.d_rs_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [2:0] typ, input logic z, input logic bz,
                         input logic [31:0] pc, input logic [15:0] imm, input logic [25:0] idx,
                         input logic [31:0] rs, input logic stl);
        ifc_a.d_valid   = vld;
        ifc_a.d_br_type = typ;
        ifc_a.d_zero    = z;
        ifc_a.d_bezal   = bz;
        ifc_a.d_pc      = pc;
        ifc_a.d_imm16   = imm;
        ifc_a.d_index26 = idx;
        ifc_a.d_rs_val  = rs;
        ifc_a.stall     = stl;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] cnt_a,
                             input logic [31:0] cnt_b, input logic err);
        chk({tag, ".f_pc"},  ifc_a.f_pc, pc);
        chk({tag, ".cnt_a"}, 32'(ifc_a.taken_cnt), cnt_a);
        chk({tag, ".cnt_b"}, 32'(ifc_b.taken_cnt), cnt_b);
        chk({tag, ".err"},   32'(ifc_a.align_err), 32'(err));
    endtask

    initial begin
        drive(1'b0, BR_NONE, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0);
        reset = 1'b0;
        repeat (3) tick();
        chk_state("reset", 32'h0000_3000, 0, 0, 1'b0);
        chk("reset.f_valid", 32'(ifc_a.f_valid), 32'd0);

        // BOOT cycle: a JAL already sitting in D must be ignored.
        reset = 1'b1;
        drive(1'b1, BR_JAL, 1'b0, 1'b0, 32'h0000_3000, 16'h0, 26'h000_0C10, 32'h0, 1'b0);
        #1;
        chk("boot.d_taken", 32'(ifc_a.d_taken), 32'd0);
        chk("boot.d_link_we", 32'(ifc_a.d_link_we), 32'd0);
        chk("boot.f_valid", 32'(ifc_a.f_valid), 32'd0);
        tick();
        chk_state("run0", 32'h0000_3000, 0, 0, 1'b0);
        chk("run0.f_valid", 32'(ifc_a.f_valid), 32'd1);

        // Bubble carrying a BEQ with zero set: no redirect.
        drive(1'b0, BR_BEQ, 1'b1, 1'b0, 32'h0000_3000, 16'h0010, 26'h0, 32'h0, 1'b0);
        #1 chk("bubble.d_taken", 32'(ifc_a.d_taken), 32'd0);
        tick();
        chk_state("bubble", 32'h0000_3004, 0, 0, 1'b0);

        drive(1'b1, BR_BEQ, 1'b1, 1'b0, 32'h0000_3008, 16'hFFFE, 26'h0, 32'h0, 1'b0);
        #1 chk("beq_t.d_taken", 32'(ifc_a.d_taken), 32'd1);
        tick();
        chk_state("beq_t", 32'h0000_3004, 1, 1, 1'b0);

        drive(1'b1, BR_BEQ, 1'b0, 1'b0, 32'h0000_3008, 16'hFFFE, 26'h0, 32'h0, 1'b0);
        #1 chk("beq_nt.d_taken", 32'(ifc_a.d_taken), 32'd0);
        tick();
        chk_state("beq_nt", 32'h0000_3008, 1, 1, 1'b0);

        drive(1'b1, BR_BNE, 1'b0, 1'b0, 32'h0000_3008, 16'h0010, 26'h0, 32'h0, 1'b0);
        tick();
        chk_state("bne_t", 32'h0000_304C, 2, 2, 1'b0);

        drive(1'b1, BR_BEZAL, 1'b0, 1'b1, 32'h0000_3010, 16'h0004, 26'h0, 32'h0, 1'b0);
        #1;
        chk("bezal_t.link_we", 32'(ifc_a.d_link_we), 32'd1);
        chk("bezal_t.link_pc", ifc_a.d_link_pc, 32'h0000_3018);
        tick();
        chk_state("bezal_t", 32'h0000_3024, 3, 3, 1'b0);

        drive(1'b1, BR_BEZAL, 1'b0, 1'b0, 32'h0000_3010, 16'h0004, 26'h0, 32'h0, 1'b0);
        #1;
        chk("bezal_nt.link_we", 32'(ifc_a.d_link_we), 32'd0);
        chk("bezal_nt.d_taken", 32'(ifc_a.d_taken), 32'd0);
        tick();
        chk_state("bezal_nt", 32'h0000_3028, 3, 3, 1'b0);

        // JAL held by two stall cycles, then released.
        drive(1'b1, BR_JAL, 1'b0, 1'b0, 32'h0000_3020, 16'h0, 26'h000_0C10, 32'h0, 1'b1);
        #1;
        chk("jal_st.d_taken", 32'(ifc_a.d_taken), 32'd1);
        chk("jal_st.link_we", 32'(ifc_a.d_link_we), 32'd1);
        chk("jal_st.link_pc", ifc_a.d_link_pc, 32'h0000_3028);
        tick();
        chk_state("jal_st1", 32'h0000_3028, 3, 3, 1'b0);
        tick();
        chk_state("jal_st2", 32'h0000_3028, 3, 3, 1'b0);
        ifc_a.stall = 1'b0;
        tick();
        chk_state("jal", 32'h0000_3040, 4, 3, 1'b0);

        drive(1'b1, 3'd7, 1'b1, 1'b1, 32'h0000_3040, 16'h0004, 26'h3FF_FFFF, 32'h0, 1'b0);
        #1 chk("type7.d_taken", 32'(ifc_a.d_taken), 32'd0);
        tick();
        chk_state("type7", 32'h0000_3044, 4, 3, 1'b0);

        // Jump region taken from d_pc+4, which crosses into the next 256MB region.
        drive(1'b1, BR_J, 1'b0, 1'b0, 32'hAFFF_FFFC, 16'h0, 26'h3FF_FFFF, 32'h0, 1'b0);
        tick();
        chk_state("j_region", 32'hBFFF_FFFC, 5, 3, 1'b0);

        drive(1'b1, BR_BEQ, 1'b1, 1'b0, 32'hFFFF_FFF8, 16'h0001, 26'h0, 32'h0, 1'b0);
        tick();
        chk_state("beq_wrap", 32'h0000_0000, 6, 3, 1'b0);

        drive(1'b1, BR_JR, 1'b0, 1'b0, 32'h0000_3030, 16'h0, 26'h0, 32'h0000_3402, 1'b0);
        tick();
        chk_state("jr_mis", 32'h0000_3402, 7, 3, 1'b1);

        drive(1'b1, BR_JR, 1'b0, 1'b0, 32'h0000_3400, 16'h0, 26'h0, 32'h0000_5000, 1'b0);
        tick();
        chk_state("jr_ok", 32'h0000_5000, 8, 3, 1'b1);

        drive(1'b0, BR_NONE, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0);
        tick();
        chk_state("idle", 32'h0000_5004, 8, 3, 1'b1);

        // Asynchronous reset between edges clears everything immediately.
        #2 reset = 1'b0;
        #1;
        chk_state("async_rst", 32'h0000_3000, 0, 0, 1'b0);
        chk("async_rst.f_valid", 32'(ifc_a.f_valid), 32'd0);
        chk("async_rst.f_valid_b", 32'(ifc_b.f_valid), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk_state("post_rst", 32'h0000_3004, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
